// File: rtl/prio_pkg.sv
// prio_pkg: shared request codes, FSM state encoding, default widths and code-to-one-hot helper
package prio_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int CODE_W    = 3;
    localparam int SVC_W     = 8;
    localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;
    localparam logic [CODE_W-1:0] CODE_MAX  = 3'd4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;
    function automatic logic [N_REQ_DEF-1:0] code2onehot(input logic [CODE_W-1:0] c);
        return (c == CODE_NONE || c > CODE_MAX) ? '0 : N_REQ_DEF'(1) << (c - 3'd1);
    endfunction
endpackage

// File: rtl/cyc_counter.sv
// cyc_counter: up-counter with synchronous clear and enable, flags when the count equals i_last
module cyc_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_hit
);
    logic [W-1:0] r_cnt;
    // clear has priority over counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + W'(1);
    end
    assign o_hit = r_cnt == i_last;
endmodule

// File: rtl/prio_grant_ctrl.sv
// prio_grant_ctrl: locks a one-hot grant from the encoder code until done, then cools down.
// Optional PGC_TIMEOUT_EN: a watchdog releases a grant held HOLD_MAX cycles without done.
module prio_grant_ctrl
    import prio_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int COOL_CYC = 2,
    parameter int HOLD_MAX = 255,
    parameter int HOLD_W   = 8,
    localparam int CW      = $clog2(N_REQ + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CW-1:0]    code,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [SVC_W-1:0] svc_cnt,
    output logic             err,
    output logic             timeout
);
    localparam int COOL_W = (COOL_CYC < 2) ? 1 : $clog2(COOL_CYC);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOL_CYC == 0) ? 0 : COOL_CYC - 1);

    logic [1:0]       r_state, w_nxt;
    logic [N_REQ-1:0] r_grant, w_oh;
    logic [SVC_W-1:0] r_svc;
    logic             r_busy, r_err, r_to;
    logic             w_idle, w_in_grant, w_in_cool, w_legal, w_take;
    logic             w_done, w_to, w_rel, w_cool_hit;

    assign w_idle     = r_state == ST_IDLE;
    assign w_in_grant = r_state == ST_GRANT;
    assign w_in_cool  = r_state == ST_COOL;
    assign w_legal    = code != CODE_NONE && code <= CW'(N_REQ);
    assign w_take     = w_idle && w_legal;
    assign w_done     = w_in_grant && done;
    assign w_rel      = w_done || w_to;
    assign w_oh       = N_REQ'(1) << (code - CW'(1));

    // cooldown length; cleared on every release so each cooldown starts from zero
    cyc_counter #(.W(COOL_W)) u_cool (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_rel),
        .i_en    (w_in_cool),
        .i_last  (COOL_LAST),
        .o_hit   (w_cool_hit)
    );

`ifdef PGC_TIMEOUT_EN
    logic w_hold_hit;
    cyc_counter #(.W(HOLD_W)) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_take),
        .i_en    (w_in_grant),
        .i_last  (HOLD_W'(HOLD_MAX - 1)),
        .o_hit   (w_hold_hit)
    );
    assign w_to = w_in_grant && !done && w_hold_hit;
`else
    logic [HOLD_W-1:0] w_unused_hold;
    assign w_unused_hold = HOLD_W'(HOLD_MAX - 1);
    assign w_to = 1'b0;
`endif

    // next state: grant on a legal code, release on done/watchdog, leave cooldown on the last count
    always_comb begin
        w_nxt = w_take ? ST_GRANT :
                w_rel ? ((COOL_CYC == 0) ? ST_IDLE : ST_COOL) :
                (w_in_cool && w_cool_hit) ? ST_IDLE : r_state;
    end

    // registered state and outputs; busy and grant follow the next state so they have no extra lag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_svc   <= '0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_busy  <= w_nxt != ST_IDLE;
            r_grant <= w_take ? w_oh : w_rel ? '0 : r_grant;
            r_svc   <= r_svc + SVC_W'(w_done);
            r_err   <= w_idle && code != CODE_NONE && !w_legal;
            r_to    <= w_to;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign svc_cnt = r_svc;
    assign err     = r_err;
    assign timeout = r_to;
endmodule

// File: tb/tb_prio_grant_ctrl.sv
// tb_prio_grant_ctrl: directed bench for prio_grant_ctrl with a per-cycle behavioural model (COOL_CYC=2 and COOL_CYC=0 instances)
module tb_prio_grant_ctrl;
    localparam int COOL0 = 2;
    localparam int COOL1 = 0;
    localparam int HOLD0 = 8;
    localparam int HOLD1 = 255;
`ifdef PGC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int SVC_AFTER_HOLD = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int SVC_AFTER_HOLD = 5;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] code [2];
    logic       done [2];
    logic [3:0] grant [2];
    logic       busy [2];
    logic [7:0] svc [2];
    logic       err [2];
    logic       tmo [2];

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    prio_grant_ctrl #(.COOL_CYC(COOL0), .HOLD_MAX(HOLD0)) u0 (
        .clk(clk), .reset_n(reset_n), .code(code[0]), .done(done[0]),
        .grant(grant[0]), .busy(busy[0]), .svc_cnt(svc[0]), .err(err[0]), .timeout(tmo[0])
    );
    prio_grant_ctrl #(.COOL_CYC(COOL1), .HOLD_MAX(HOLD1)) u1 (
        .clk(clk), .reset_n(reset_n), .code(code[1]), .done(done[1]),
        .grant(grant[1]), .busy(busy[1]), .svc_cnt(svc[1]), .err(err[1]), .timeout(tmo[1])
    );

    // model: who owns the resource, how many cooldown cycles remain, how long the owner has held it
    int owner [2] = '{-1, -1};
    int cool_left [2] = '{0, 0};
    int age [2] = '{0, 0};
    int m_svc [2] = '{0, 0};
    bit m_err [2] = '{0, 0};
    bit m_to [2] = '{0, 0};

    function automatic int cool_of(input int d);
        return d == 0 ? COOL0 : COOL1;
    endfunction

    function automatic int hold_of(input int d);
        return d == 0 ? HOLD0 : HOLD1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                owner[d] <= -1;
                cool_left[d] <= 0;
                age[d] <= 0;
                m_svc[d] <= 0;
                m_err[d] <= 1'b0;
                m_to[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_err[d] <= 1'b0;
                m_to[d] <= 1'b0;
                if (owner[d] >= 0) begin
                    if (done[d]) begin
                        m_svc[d] <= (m_svc[d] + 1) % 256;
                        owner[d] <= -1;
                        cool_left[d] <= cool_of(d);
                    end else if (TO_EN && age[d] == hold_of(d) - 1) begin
                        owner[d] <= -1;
                        cool_left[d] <= cool_of(d);
                        m_to[d] <= 1'b1;
                    end else begin
                        age[d] <= age[d] + 1;
                    end
                end else if (cool_left[d] > 0) begin
                    cool_left[d] <= cool_left[d] - 1;
                end else if (code[d] >= 3'd1 && code[d] <= 3'd4) begin
                    owner[d] <= int'(code[d]) - 1;
                    age[d] <= 0;
                end else if (code[d] >= 3'd5) begin
                    m_err[d] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison of both instances against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("u%0d.grant", d), 8'(grant[d]), owner[d] < 0 ? 8'd0 : 8'(1 << owner[d]));
                chk($sformatf("u%0d.busy", d), 8'(busy[d]), 8'(owner[d] >= 0 || cool_left[d] > 0));
                chk($sformatf("u%0d.svc_cnt", d), svc[d], 8'(m_svc[d]));
                chk($sformatf("u%0d.err", d), 8'(err[d]), 8'(m_err[d]));
                chk($sformatf("u%0d.timeout", d), 8'(tmo[d]), 8'(m_to[d]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        code[0] = 3'd0; code[1] = 3'd0; done[0] = 1'b0; done[1] = 1'b0;
        #1 reset_n = 1'b0;
        #2 chk_on = 1'b1;
        tick(2);
        chk("rst.grant", 8'(grant[0]), 8'h00);
        chk("rst.busy", 8'(busy[0]), 8'h00);
        chk("rst.svc", svc[0], 8'h00);
        chk("rst.err", 8'(err[0]), 8'h00);
        chk("rst.timeout", 8'(tmo[0]), 8'h00);
        reset_n = 1'b1;
        // basic grant, done, cooldown of two cycles
        code[0] = 3'd3; tick(1);
        chk("basic.grant", 8'(grant[0]), 8'h04);
        chk("basic.busy", 8'(busy[0]), 8'h01);
        code[0] = 3'd0; tick(3);
        chk("basic.hold", 8'(grant[0]), 8'h04);
        done[0] = 1'b1; tick(1);
        chk("basic.release", 8'(grant[0]), 8'h00);
        chk("basic.svc", svc[0], 8'h01);
        chk("basic.cool_busy", 8'(busy[0]), 8'h01);
        done[0] = 1'b0; tick(1);
        chk("basic.cool_busy2", 8'(busy[0]), 8'h01);
        tick(1);
        chk("basic.idle", 8'(busy[0]), 8'h00);
        // lock: a higher-priority code cannot preempt
        code[0] = 3'd1; tick(1);
        chk("lock.grant", 8'(grant[0]), 8'h01);
        code[0] = 3'd4; tick(3);
        chk("lock.frozen", 8'(grant[0]), 8'h01);
        done[0] = 1'b1; tick(1);
        chk("lock.release", 8'(grant[0]), 8'h00);
        done[0] = 1'b0; tick(2);
        chk("lock.cool", 8'(grant[0]), 8'h00);
        tick(1);
        chk("lock.regrant", 8'(grant[0]), 8'h08);
        // done and code change on the same edge: done wins
        done[0] = 1'b1; code[0] = 3'd2; tick(1);
        chk("simul.release", 8'(grant[0]), 8'h00);
        chk("simul.svc", svc[0], 8'h03);
        done[0] = 1'b0; tick(2);
        chk("simul.cool", 8'(grant[0]), 8'h00);
        tick(1);
        chk("simul.regrant", 8'(grant[0]), 8'h02);
        done[0] = 1'b1; code[0] = 3'd0; tick(1);
        done[0] = 1'b0; tick(2);
        // illegal code and stray done in IDLE
        code[0] = 3'd6; tick(1);
        chk("illegal.err", 8'(err[0]), 8'h01);
        chk("illegal.grant", 8'(grant[0]), 8'h00);
        chk("illegal.busy", 8'(busy[0]), 8'h00);
        code[0] = 3'd0; tick(1);
        chk("illegal.err_clear", 8'(err[0]), 8'h00);
        done[0] = 1'b1; tick(1);
        chk("idle_done.busy", 8'(busy[0]), 8'h00);
        chk("idle_done.svc", svc[0], 8'h04);
        done[0] = 1'b0;
        // long hold: watchdog release when enabled, indefinite hold otherwise
        code[0] = 3'd2; tick(1);
        chk("hold.grant", 8'(grant[0]), 8'h02);
        code[0] = 3'd0; tick(7);
        chk("hold.k7", 8'(grant[0]), 8'h02);
        chk("hold.k7_to", 8'(tmo[0]), 8'h00);
        tick(1);
`ifdef PGC_TIMEOUT_EN
        chk("wdog.grant", 8'(grant[0]), 8'h00);
        chk("wdog.timeout", 8'(tmo[0]), 8'h01);
        chk("wdog.svc", svc[0], 8'h04);
        tick(1);
        chk("wdog.pulse_end", 8'(tmo[0]), 8'h00);
        tick(2);
`else
        chk("nowdog.grant", 8'(grant[0]), 8'h02);
        chk("nowdog.timeout", 8'(tmo[0]), 8'h00);
        tick(300);
        chk("nowdog.long", 8'(grant[0]), 8'h02);
        done[0] = 1'b1; tick(1);
        done[0] = 1'b0;
        chk("nowdog.svc", svc[0], 8'h05);
        tick(2);
`endif
        // done on the watchdog edge is an ordinary completion
        code[0] = 3'd1; tick(1);
        code[0] = 3'd0; tick(7);
        done[0] = 1'b1; tick(1);
        chk("edge_done.grant", 8'(grant[0]), 8'h00);
        chk("edge_done.timeout", 8'(tmo[0]), 8'h00);
        chk("edge_done.svc", svc[0], 8'(SVC_AFTER_HOLD + 1));
        done[0] = 1'b0; tick(2);
        // asynchronous reset mid-grant
        code[0] = 3'd3; tick(1);
        chk("arst.pre", 8'(grant[0]), 8'h04);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.grant", 8'(grant[0]), 8'h00);
        chk("arst.busy", 8'(busy[0]), 8'h00);
        chk("arst.svc", svc[0], 8'h00);
        code[0] = 3'd0; tick(1);
        reset_n = 1'b1;
        tick(1);
        // zero cooldown: 256 back-to-back grants wrap the service counter
        code[1] = 3'd1;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            chk("wrap.grant", 8'(grant[1]), 8'h01);
            done[1] = 1'b1; tick(1);
            chk("wrap.release", 8'(grant[1]), 8'h00);
            if (i == 254) chk("wrap.svc255", svc[1], 8'hff);
            done[1] = 1'b0;
        end
        chk("wrap.svc0", svc[1], 8'h00);
        code[1] = 3'd0; tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/prio_grant_ctrl.md
Name: prio_grant_ctrl

Overview:
Downstream stage of the 4-input priority encoder. Consumes the encoder's 3-bit code and turns it into a registered one-hot grant that stays locked until the requester signals done. After each grant it enforces a cooldown, then re-arbitrates. Sits between the request encoder and the shared resource it guards (LED/display/peripheral mux on the board).

Parameters:
- N_REQ, 4: number of request lines; code width is clog2(N_REQ+1) = 3.
- COOL_CYC, 2: idle cycles after a grant releases before the next grant may issue; 0 is legal.
- HOLD_MAX, 255: watchdog limit in cycles. Used only with PGC_TIMEOUT_EN.
- HOLD_W, 8: width of the hold counter; must hold HOLD_MAX.

Ports:
- clk, in, 1: system clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- code, in, 3: encoder output. 0 = no request; 1..4 = request line (code-1) wins, with 4 as highest priority.
- done, in, 1: owner finished; sampled only in GRANT.
- grant, out, 4: registered one-hot grant; bit (code-1) is set.
- busy, out, 1: high whenever state is not IDLE.
- svc_cnt, out, 8: count of completed grants; wraps from 255 to 0.
- err, out, 1: one-cycle pulse on an illegal code (5..7) sampled in IDLE.
- timeout, out, 1: one-cycle pulse on watchdog release. Tied to 0 when PGC_TIMEOUT_EN is not defined.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE.
  - grant=0, busy=0, svc_cnt=0, err=0, timeout=0.
  - Cool and hold counters=0.
  - Reset mid-GRANT drops grant immediately, without waiting for a clock edge.
- All outputs are registered.
- States are IDLE, GRANT and COOL.
- IDLE:
  - code in 1..4 at edge k: latch cur_code, go to GRANT. grant[code-1]=1 and busy=1 become visible after edge k (1-cycle latency).
  - code=0: stay in IDLE, no change.
  - code in 5..7: stay in IDLE and pulse err for the one cycle after the edge.
  - done is ignored.
- GRANT:
  - grant is frozen to cur_code. Any change on code is ignored, including a higher-priority code.
  - done=1 at edge m:
    - grant=0 after edge m.
    - svc_cnt increments after edge m.
    - If COOL_CYC>0, go to COOL with cool counter cleared.
    - If COOL_CYC=0, go straight to IDLE.
- COOL:
  - The cool counter increments each edge. When it reaches COOL_CYC-1, go to IDLE.
  - In total the FSM spends COOL_CYC cycles in COOL, with busy=1 throughout.
  - code and done are ignored.
- Earliest re-grant timing:
  - A code held at 1..4 is re-granted after edge m+COOL_CYC+1.
  - With COOL_CYC=0 this is after edge m+1.
- Simultaneous done and code change in GRANT: done wins. The new code is not considered until IDLE.
- svc_cnt wraps from 255 to 0 with no flag.
- A same-line request after cooldown is granted again. There is no fairness rotation; priority is strictly the encoder's.

Optional Feature:
- Macro: PGC_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each cycle spent in GRANT.
  - If it reaches HOLD_MAX-1 with done=0, the FSM releases as if done had been asserted: grant=0, then COOL.
  - timeout pulses for 1 cycle.
  - svc_cnt does NOT increment.
  - If done=1 on the same edge, it counts as a normal completion with no timeout pulse.
- Not defined:
  - No hold counter is built and timeout is tied to 0.
  - grant is held indefinitely until done.

Decomposition:
- Shared package prio_pkg holds:
  - Code constants: CODE_NONE=3'd0, CODE_MAX=3'd4.
  - State encoding: IDLE, GRANT, COOL.
  - Default widths.
  - The code-to-one-hot mapping function, also reusable by the encoder bench.
- Sub-module: none required. The cooldown/hold counter is a small generic up-counter with clear, load-compare, named cyc_counter and instantiated once for cool and once for hold (hold only under PGC_TIMEOUT_EN).

Test Plan:
- Reset: reset_n=0 mid-GRANT with grant=4'b0100 -> grant=0 and busy=0 with no clock edge; svc_cnt=0.
- Basic grant: code=3'd3 at edge 1 -> grant=4'b0100 after edge 1; done at edge 5 -> grant=0, svc_cnt=1; busy low after edge 7 (COOL_CYC=2).
- Lock: in GRANT for code 1 (grant=4'b0001), drive code=3'd4 -> grant stays 4'b0001 until done; code 4 is granted 4'b1000 after edge m+3.
- Illegal/idle: code=3'd6 in IDLE -> err one cycle, grant=0, state stays IDLE; done=1 in IDLE -> no effect.
- Wrap and zero cooldown: COOL_CYC=0, 256 back-to-back grant/done pairs -> svc_cnt returns to 0 and each re-grant arrives 1 cycle after done.
- PGC_TIMEOUT_EN, HOLD_MAX=8: code=2 with done never asserted -> grant 4'b0010 drops after 8 cycles in GRANT, timeout pulses once, svc_cnt unchanged.
